// File: rtl/dmem_uart_loader_pkg.sv
// Shared types and constants for the UART-to-dmem preload engine.
package loader_pkg;

   localparam int DMEM_ADDR_W    = 14;
   localparam int DMEM_DATA_W    = 256;
   localparam int BYTES_PER_WORD = 32;

   localparam logic [BYTES_PER_WORD-1:0] BYTEENA_ALL = '1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      WRITE   = 2'd2,
      DONE    = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/dmem_uart_loader_if.sv
// dmem write port as seen from the loader (master) and the memory (slave).
interface dmem_uart_loader_if
   import loader_pkg::*;
   ();

   logic [DMEM_ADDR_W-1:0]    address_RAM;
   logic [BYTES_PER_WORD-1:0] byteena_RAM;
   logic [DMEM_DATA_W-1:0]    writeData_RAM;
   logic                      wren_RAM;

   modport master (
      output address_RAM,
      output byteena_RAM,
      output writeData_RAM,
      output wren_RAM
   );

   modport slave (
      input address_RAM,
      input byteena_RAM,
      input writeData_RAM,
      input wren_RAM
   );

endinterface

// File: rtl/dmem_uart_loader_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, glitch rejection.
module uart_rx
   import loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       stop_err
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

   logic             sync1_q, sync2_q, prev_q;
   rx_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;

   // Synchronise rx and keep the previous synchronised value for edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= rx;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // Receiver state, bit timer, bit index and shift register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   // Next state: half-bit wait to re-check start, then full-bit steps to each mid-bit.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (prev_q && !sync2_q) state_d = RX_START;
         end
         RX_START: begin
            if (cnt_q == HALF_CNT) begin
               cnt_d   = '0;
               state_d = sync2_q ? RX_IDLE : RX_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (cnt_q == FULL_CNT) begin
               cnt_d   = '0;
               shift_d = {sync2_q, shift_q[7:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == 3'd7) state_d = RX_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt_q == FULL_CNT) state_d = RX_IDLE;
            else                   cnt_d   = cnt_q + 1'b1;
         end
         default: state_d = RX_IDLE;
      endcase
   end

   // Outputs: single-cycle pulses at the stop-bit sample point.
   always_comb begin
      byte_data  = shift_q;
      byte_valid = (state_q == RX_STOP) && (cnt_q == FULL_CNT) && sync2_q;
      stop_err   = (state_q == RX_STOP) && (cnt_q == FULL_CNT) && !sync2_q;
   end

endmodule

// File: rtl/dmem_uart_loader.sv
// Packs UART bytes into 256-bit words and writes them to consecutive dmem addresses.
module dmem_uart_loader
   import loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int WORD_COUNT   = 1024
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                rx,
   input  logic                enable,
   dmem_uart_loader_if.master  dmem,
   output logic                proc_hold,
   output logic                busy,
   output logic                done,
   output logic                frame_err
);

   localparam logic [DMEM_ADDR_W-1:0] LAST_WORD = DMEM_ADDR_W'(WORD_COUNT - 1);

   logic [7:0] byte_data;
   logic       byte_valid;
   logic       stop_err;

   state_t                  state_q, state_d;
   logic [4:0]              byte_idx_q, byte_idx_d;
   logic [DMEM_ADDR_W-1:0]  word_cnt_q, word_cnt_d;
   logic [DMEM_DATA_W-1:0]  buf_q, buf_d;
   logic                    frame_err_q;

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .stop_err   (stop_err)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Datapath registers: lane index, word address and assembly buffer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         byte_idx_q <= '0;
         word_cnt_q <= '0;
         buf_q      <= '0;
      end else begin
         byte_idx_q <= byte_idx_d;
         word_cnt_q <= word_cnt_d;
         buf_q      <= buf_d;
      end
   end

   // Sticky framing error, cleared only by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        frame_err_q <= 1'b0;
      else if (stop_err) frame_err_q <= 1'b1;
   end

   // Next state and datapath; dropping enable anywhere before DONE aborts the session.
   always_comb begin
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      word_cnt_d = word_cnt_q;
      buf_d      = buf_q;
      case (state_q)
         IDLE: begin
            byte_idx_d = '0;
            word_cnt_d = '0;
            buf_d      = '0;
            if (enable) state_d = COLLECT;
         end
         COLLECT: begin
            if (!enable) begin
               state_d    = IDLE;
               byte_idx_d = '0;
               word_cnt_d = '0;
               buf_d      = '0;
            end else if (byte_valid) begin
               buf_d[{byte_idx_q, 3'b000} +: 8] = byte_data;
               byte_idx_d = byte_idx_q + 1'b1;
               if (byte_idx_q == 5'd31) state_d = WRITE;
            end
         end
         WRITE: begin
            if (!enable) begin
               state_d    = IDLE;
               byte_idx_d = '0;
               word_cnt_d = '0;
               buf_d      = '0;
            end else begin
               if (word_cnt_q == LAST_WORD) begin
                  state_d = DONE;
               end else begin
                  state_d    = COLLECT;
                  word_cnt_d = word_cnt_q + 1'b1;
               end
               // A byte landing during the write cycle starts the next word.
               if (byte_valid) begin
                  buf_d[7:0] = byte_data;
                  byte_idx_d = 5'd1;
               end
            end
         end
         DONE: begin
            if (!enable) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from state; the dmem port only strobes in WRITE.
   always_comb begin
      proc_hold          = (state_q != IDLE);
      busy               = (state_q == COLLECT) || (state_q == WRITE);
      done               = (state_q == DONE);
      frame_err          = frame_err_q;
      dmem.wren_RAM      = (state_q == WRITE);
      dmem.byteena_RAM   = (state_q == WRITE) ? BYTEENA_ALL : '0;
      dmem.address_RAM   = word_cnt_q;
      dmem.writeData_RAM = buf_q;
   end

endmodule

// File: tb/tb_dmem_uart_loader.sv
// Scoreboard bench: expected dmem writes are queued by the stimulus, checked by a monitor.
module tb_dmem_uart_loader;
   import loader_pkg::*;

   localparam int CPB = 16;
   localparam int WC  = 2;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic rx = 1'b1;
   logic enable = 1'b0;
   logic proc_hold, busy, done, frame_err;

   dmem_uart_loader_if dmem_bus ();

   dmem_uart_loader #(.CLKS_PER_BIT(CPB), .WORD_COUNT(WC)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .enable    (enable),
      .dmem      (dmem_bus.master),
      .proc_hold (proc_hold),
      .busy      (busy),
      .done      (done),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [13:0]  addr;
      logic [255:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   last_bv = -100;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(CPB);
      end
      rx = stop;
      tick(CPB);
      rx = 1'b1;
      tick(4);
   endtask

   task automatic expect_write(input logic [13:0] a, input logic [255:0] d);
      exp_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   function automatic logic [255:0] fill(input logic [7:0] b);
      logic [255:0] r;
      for (int i = 0; i < 32; i++) r[i*8 +: 8] = b;
      return r;
   endfunction

   task automatic do_reset();
      enable = 1'b0;
      rx     = 1'b1;
      reset  = 1'b0;
      tick(3);
      reset  = 1'b1;
      tick(2);
   endtask

   // Monitor: every write strobe is matched against the head of the scoreboard.
   always @(negedge clk) begin
      cyc++;
      if (dmem_bus.wren_RAM) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_write: got addr %0d expected no write", dmem_bus.address_RAM);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            $display("write addr=%0d data=%h", dmem_bus.address_RAM, dmem_bus.writeData_RAM);
            chk("wr_addr", 256'(dmem_bus.address_RAM), 256'(e.addr));
            chk("wr_byteena", 256'(dmem_bus.byteena_RAM), 256'(32'hFFFF_FFFF));
            chk("wr_data", dmem_bus.writeData_RAM, e.data);
            chk("wr_latency", 256'(cyc), 256'(last_bv + 1));
         end
      end
      if (dut.byte_valid) last_bv = cyc;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [255:0] d;

      // Reset state.
      tick(3);
      chk("rst_wren", 256'(dmem_bus.wren_RAM), 256'(0));
      chk("rst_byteena", 256'(dmem_bus.byteena_RAM), 256'(0));
      chk("rst_addr", 256'(dmem_bus.address_RAM), 256'(0));
      chk("rst_data", dmem_bus.writeData_RAM, 256'(0));
      chk("rst_flags", 256'({proc_hold, busy, done, frame_err}), 256'(0));
      reset = 1'b1;
      tick(2);

      // 1: first word 0x00..0x1F at address 0.
      enable = 1'b1;
      tick(2);
      chk("t1_busy", 256'(busy), 256'(1));
      chk("t1_hold", 256'(proc_hold), 256'(1));
      for (int i = 0; i < 32; i++) d[i*8 +: 8] = 8'(i);
      expect_write(14'd0, d);
      for (int i = 0; i < 32; i++) send_byte(8'(i), 1'b1);
      chk("t1_written", 256'(exp_q.size()), 256'(0));
      chk("t1_busy_after", 256'(busy), 256'(1));

      // 2: second word 0x20..0x3F at address 1, then DONE.
      for (int i = 0; i < 32; i++) d[i*8 +: 8] = 8'(32 + i);
      expect_write(14'd1, d);
      for (int i = 32; i < 64; i++) send_byte(8'(i), 1'b1);
      chk("t2_written", 256'(exp_q.size()), 256'(0));
      chk("t2_done", 256'(done), 256'(1));
      chk("t2_busy", 256'(busy), 256'(0));
      chk("t2_hold", 256'(proc_hold), 256'(1));
      send_byte(8'hEE, 1'b1);
      send_byte(8'hEF, 1'b1);
      chk("t2_done_stays", 256'(done), 256'(1));
      enable = 1'b0;
      tick(2);
      chk("t2_done_clr", 256'(done), 256'(0));
      chk("t2_hold_clr", 256'(proc_hold), 256'(0));

      // 3: bad stop bit sets sticky frame_err and occupies no lane.
      do_reset();
      enable = 1'b1;
      tick(2);
      send_byte(8'h55, 1'b0);
      chk("t3_ferr", 256'(frame_err), 256'(1));
      expect_write(14'd0, fill(8'hAA));
      for (int i = 0; i < 32; i++) send_byte(8'hAA, 1'b1);
      chk("t3_written", 256'(exp_q.size()), 256'(0));
      chk("t3_ferr_sticky", 256'(frame_err), 256'(1));

      // 4: abort mid-word, restart from address 0.
      do_reset();
      enable = 1'b1;
      tick(2);
      for (int i = 0; i < 10; i++) send_byte(8'h11, 1'b1);
      enable = 1'b0;
      tick(1);
      chk("t4_abort_busy", 256'(busy), 256'(0));
      enable = 1'b1;
      tick(1);
      expect_write(14'd0, fill(8'hA5));
      for (int i = 0; i < 32; i++) send_byte(8'hA5, 1'b1);
      chk("t4_written", 256'(exp_q.size()), 256'(0));

      // 5: asynchronous reset mid-word clears outputs without a clock edge.
      do_reset();
      enable = 1'b1;
      tick(2);
      for (int i = 0; i < 17; i++) send_byte(8'h77, 1'b1);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("t5_data", dmem_bus.writeData_RAM, 256'(0));
      chk("t5_addr", 256'(dmem_bus.address_RAM), 256'(0));
      chk("t5_wr", 256'({dmem_bus.wren_RAM, dmem_bus.byteena_RAM}), 256'(0));
      chk("t5_flags", 256'({proc_hold, busy, done, frame_err}), 256'(0));
      tick(2);
      reset = 1'b1;
      tick(2);
      expect_write(14'd0, fill(8'h5A));
      for (int i = 0; i < 32; i++) send_byte(8'h5A, 1'b1);
      chk("t5_written", 256'(exp_q.size()), 256'(0));

      // 6: short low glitch is rejected; next frame lands in lane 0.
      do_reset();
      enable = 1'b1;
      tick(2);
      rx = 1'b0;
      tick(5);
      rx = 1'b1;
      tick(30);
      chk("t6_ferr", 256'(frame_err), 256'(0));
      d[7:0] = 8'h3C;
      for (int i = 1; i < 32; i++) d[i*8 +: 8] = 8'(8'hC0 + i);
      expect_write(14'd0, d);
      send_byte(8'h3C, 1'b1);
      for (int i = 1; i < 32; i++) send_byte(8'(8'hC0 + i), 1'b1);
      chk("t6_written", 256'(exp_q.size()), 256'(0));
      chk("t6_ferr_after", 256'(frame_err), 256'(0));
      enable = 1'b0;
      tick(5);

      chk("final_queue_empty", 256'(exp_q.size()), 256'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_uart_loader.md
Name: dmem_uart_loader

Overview:
Host-to-data-memory preload engine that sits directly upstream of dmem. It receives a byte stream over UART and packs each group of 32 bytes into one 256-bit word. Each word is written into consecutive dmem addresses through the 14-bit address / 32-bit byte-enable / 256-bit write port. While it runs, the SIMD processor is held off the memory port, so test images and data sets load without resynthesising the memory init file.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200 baud); must be at least 4.
WORD_COUNT, 1024, number of 256-bit words loaded per session, range 1..16384.

Ports:
clk  in  1  system clock (same clk that drives dmem).
reset  in  1  asynchronous, active-low reset.
rx  in  1  UART receive line; asynchronous to clk; idle high; 8N1 framing, LSB first.
enable  in  1  arms the loader; level-sensitive.
address_RAM  out  14  dmem word address.
byteena_RAM  out  32  dmem byte enables.
writeData_RAM  out  256  dmem write data.
wren_RAM  out  1  dmem write strobe.
proc_hold  out  1  high while loading; top muxes the dmem port to the loader and holds the processor in reset.
busy  out  1  loader is in COLLECT or WRITE.
done  out  1  all WORD_COUNT words have been written.
frame_err  out  1  sticky flag: at least one byte had a bad stop bit.

Behaviour:
- Reset (reset=0) takes effect immediately and asynchronously. Every output goes to 0, state goes to IDLE, and all counters and the assembly buffer clear.
- rx passes through a 2-flop synchroniser before any sampling.
- UART receive:
  - Start is detected on a falling edge of the synchronised rx.
  - At CLKS_PER_BIT/2 the start bit is re-checked. If rx is high, the event is a glitch and the receiver returns to idle.
  - Data bits are sampled at mid-bit, every CLKS_PER_BIT cycles, LSB first.
  - The stop bit is sampled at mid-bit. If it is 1, byte_valid pulses for 1 cycle with the byte. If it is 0, the byte is dropped and frame_err is set; frame_err clears only on reset.
  - After the stop sample the receiver returns to idle.
- Loader FSM states: IDLE, COLLECT, WRITE, DONE.
  - IDLE: proc_hold=0, busy=0. If enable=1, go to COLLECT next cycle with byte_idx=0 and word_cnt=0.
  - COLLECT: proc_hold=1, busy=1. On byte_valid, the byte goes into lane byte_idx (bits 8*byte_idx+7 : 8*byte_idx), and byte_idx increments (5-bit). On the byte_valid where byte_idx=31, go to WRITE.
  - WRITE: lasts exactly 1 cycle. wren_RAM=1, byteena_RAM=all ones, address_RAM=word_cnt, writeData_RAM=assembled buffer.
    - Next state is DONE if word_cnt=WORD_COUNT-1; otherwise COLLECT, with word_cnt incremented.
    - A byte_valid arriving in this cycle is stored in lane 0 of the next word with byte_idx=1. This cannot occur at legal CLKS_PER_BIT but is required anyway.
  - DONE: done=1, busy=0, proc_hold=1. Bytes received here are ignored. When enable=0, go to IDLE with done cleared.
- Outside WRITE: wren_RAM=0 and byteena_RAM=0. address_RAM and writeData_RAM hold their last values and are don't-care.
- enable=0 while in COLLECT or WRITE: abort to IDLE next cycle. No write is issued after the abort cycle; a partial word is discarded and counters clear. Words already written stay in memory.
- A partial final word is never written; the host must send a multiple of 32 bytes.
- Write latency: the dmem write occurs in the clk cycle immediately after the 32nd byte_valid of that word.
- word_cnt is 14 bits. With WORD_COUNT=16384 the last address is 16383, and the loader stops in DONE rather than wrapping.

Decomposition:
- Package loader_pkg contains:
  - the state enum (IDLE, COLLECT, WRITE, DONE);
  - DMEM_ADDR_W=14, DMEM_DATA_W=256, BYTES_PER_WORD=32;
  - the byteena all-ones constant.
- Sub-module uart_rx (parameter CLKS_PER_BIT) contains the synchroniser, bit timer and shift register. Its outputs are byte_data[7:0], byte_valid and stop_err (1-cycle pulse).
- Framing, FSM and the dmem interface stay in dmem_uart_loader.

Test Plan:
(All tests use CLKS_PER_BIT=16 and WORD_COUNT=2.)
1. enable=1, send bytes 0x00..0x1F -> one wren_RAM pulse with address_RAM=0, byteena_RAM=32'hFFFFFFFF, writeData_RAM=256'h1F1E...0100, exactly 1 cycle after the 32nd byte_valid; busy=1, proc_hold=1.
2. Continue with bytes 0x20..0x3F -> write at address_RAM=1 with data 256'h3F3E...2120, then done=1, busy=0. Extra bytes produce no writes. Dropping enable gives done=0 and proc_hold=0.
3. Send byte 0x55 with stop bit 0, then 32 good bytes of 0xAA -> frame_err=1 and stays 1. The single write has data all 0xAA (the bad byte does not occupy a lane).
4. Send 10 bytes, drop enable for 1 cycle, re-raise it, then send 32 bytes of 0xA5 -> no write during the first attempt; the next write is address 0 with data all 0xA5.
5. Assert reset low mid-word (byte 17) -> all outputs 0 in the same cycle without waiting for a clock edge. After release with enable=1, 32 fresh bytes produce a write at address 0 containing only the new data.
6. Drive rx low for 5 cycles, then high -> no byte_valid and frame_err unchanged. A following valid frame 0x3C is received and lands in lane 0.
